// File: rtl/ram_access_seq.sv
// ram_access_seq: drives the FIR coefficient-RAM command bus.
// Turns sample strobes into broadcast read bursts and coefficient
// write streams into RAM writes.
// Ports:
//   iClk12M, iRst          : clock, synchronous active-high reset
//   iEnSample600k          : one-cycle sample strobe
//   iCoeffUpdateFlag       : level, coefficient load session
//   iCoeffValid/iCoeffData : coefficient stream in
//   oCoeffReady            : stream ready (combinational)
//   oCsnRam/oWrnRam        : RAM chip select / write enable, active low
//   oAddrRam/oWtDtRam      : {bank,tap} address and write data
//   oBusy/oUpdDone/oSmplDrop : status
module ram_access_seq #(
   parameter int P_TAPS  = 10,
   parameter int P_BANKS = 4,
   parameter int P_DW    = 16
) (
   input  logic            iClk12M,
   input  logic            iRst,
   input  logic            iEnSample600k,
   input  logic            iCoeffUpdateFlag,
   input  logic            iCoeffValid,
   input  logic [P_DW-1:0] iCoeffData,
   output logic            oCoeffReady,
   output logic            oCsnRam,
   output logic            oWrnRam,
   output logic [5:0]      oAddrRam,
   output logic [P_DW-1:0] oWtDtRam,
   output logic            oBusy,
   output logic            oUpdDone,
   output logic            oSmplDrop
);

   typedef enum logic [1:0] {
      IDLE,
      RDBURST,
      UPDATE,
      UPDFULL
   } state_t;

   // Read bursts count one past the last tap so the final read
   // still shows oBusy high before returning to IDLE.
   localparam logic [3:0] TAP_LAST  = 4'(P_TAPS - 1);
   localparam logic [3:0] TAP_END   = 4'(P_TAPS);
   localparam logic [1:0] BANK_LAST = 2'(P_BANKS - 1);

   state_t     state;
   logic [3:0] tap;
   logic [1:0] bank;

   assign oCoeffReady = (state == UPDATE) && iCoeffUpdateFlag;

   always_ff @(posedge iClk12M) begin
      if (iRst) begin
         state     <= IDLE;
         tap       <= '0;
         bank      <= '0;
         oCsnRam   <= 1'b1;
         oWrnRam   <= 1'b1;
         oAddrRam  <= '0;
         oWtDtRam  <= '0;
         oBusy     <= 1'b0;
         oUpdDone  <= 1'b0;
         oSmplDrop <= 1'b0;
      end else begin
         oCsnRam  <= 1'b1;
         oWrnRam  <= 1'b1;
         oUpdDone <= 1'b0;
         // A strobe is only serviced from IDLE when no load is pending.
         oSmplDrop <= iEnSample600k &&
                      ((state != IDLE) || iCoeffUpdateFlag);
         unique case (state)
            IDLE: begin
               if (iCoeffUpdateFlag) begin
                  state <= UPDATE;
                  tap   <= '0;
                  bank  <= '0;
                  oBusy <= 1'b1;
               end else if (iEnSample600k) begin
                  state    <= RDBURST;
                  oCsnRam  <= 1'b0;
                  oAddrRam <= 6'd0;
                  tap      <= 4'd1;
                  oBusy    <= 1'b1;
               end
            end
            RDBURST: begin
               if (tap == TAP_END) begin
                  state <= IDLE;
                  tap   <= '0;
                  oBusy <= 1'b0;
               end else begin
                  oCsnRam  <= 1'b0;
                  oAddrRam <= {2'b00, tap};
                  tap      <= tap + 4'd1;
               end
            end
            UPDATE: begin
               if (!iCoeffUpdateFlag) begin
                  state <= IDLE;
                  tap   <= '0;
                  bank  <= '0;
                  oBusy <= 1'b0;
               end else if (iCoeffValid) begin
                  oCsnRam  <= 1'b0;
                  oWrnRam  <= 1'b0;
                  oAddrRam <= {bank, tap};
                  oWtDtRam <= iCoeffData;
                  if (tap == TAP_LAST) begin
                     tap <= '0;
                     if (bank == BANK_LAST) begin
                        bank     <= '0;
                        state    <= UPDFULL;
                        oUpdDone <= 1'b1;
                     end else begin
                        bank <= bank + 2'd1;
                     end
                  end else begin
                     tap <= tap + 4'd1;
                  end
               end
            end
            UPDFULL: begin
               if (!iCoeffUpdateFlag) begin
                  state <= IDLE;
                  oBusy <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               oBusy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_access_seq.sv
// tb_ram_access_seq: directed and random stimulus against a
// transaction-level model of the RAM command bus.
module tb_ram_access_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        strobe;
   logic        flag;
   logic        valid;
   logic [15:0] data;
   logic        ready;
   logic        csn;
   logic        wrn;
   logic [5:0]  addr;
   logic [15:0] wdata;
   logic        busy;
   logic        done;
   logic        drop;

   int tests = 0;
   int fails = 0;

   // model state: 0 idle, 1 reading, 2 loading, 3 full
   int m_mode = 0;
   int m_rd = 0;
   int m_wr = 0;
   int e_csn = 1, e_wrn = 1, e_addr = 0, e_data = 0;
   int e_busy = 0, e_done = 0, e_drop = 0;
   int done_cnt = 0, drop_cnt = 0, read_cnt = 0;

   ram_access_seq dut (
      .iClk12M         (clk),
      .iRst            (rst),
      .iEnSample600k   (strobe),
      .iCoeffUpdateFlag(flag),
      .iCoeffValid     (valid),
      .iCoeffData      (data),
      .oCoeffReady     (ready),
      .oCsnRam         (csn),
      .oWrnRam         (wrn),
      .oAddrRam        (addr),
      .oWtDtRam        (wdata),
      .oBusy           (busy),
      .oUpdDone        (done),
      .oSmplDrop       (drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Outputs expected after an edge, from the sampled inputs.
   task automatic model_step();
      if (rst) begin
         m_mode = 0; m_rd = 0; m_wr = 0;
         e_csn = 1; e_wrn = 1; e_addr = 0; e_data = 0;
         e_done = 0; e_drop = 0;
      end else begin
         e_csn = 1; e_wrn = 1; e_done = 0;
         e_drop = (strobe && !(m_mode == 0 && !flag)) ? 1 : 0;
         case (m_mode)
            0: if (flag) begin
                  m_mode = 2; m_wr = 0;
               end else if (strobe) begin
                  m_mode = 1;
                  e_csn = 0; e_addr = 0; m_rd = 1;
               end
            1: if (m_rd < 10) begin
                  e_csn = 0; e_addr = m_rd; m_rd++;
               end else m_mode = 0;
            2: if (!flag) begin
                  m_mode = 0; m_wr = 0;
               end else if (valid) begin
                  e_csn = 0; e_wrn = 0;
                  e_addr = (m_wr / 10) * 16 + (m_wr % 10);
                  e_data = int'(data);
                  m_wr++;
                  if (m_wr == 40) begin
                     m_mode = 3; e_done = 1;
                  end
               end
            default: if (!flag) m_mode = 0;
         endcase
      end
      e_busy = (m_mode != 0) ? 1 : 0;
   endtask

   task automatic compare();
      chk("csn", int'(csn), e_csn);
      chk("wrn", int'(wrn), e_wrn);
      chk("addr", int'(addr), e_addr);
      if (e_csn == 0 && e_wrn == 0) chk("wdata", int'(wdata), e_data);
      chk("busy", int'(busy), e_busy);
      chk("upd_done", int'(done), e_done);
      chk("smpl_drop", int'(drop), e_drop);
      chk("ready", int'(ready), (m_mode == 2 && flag) ? 1 : 0);
      if (done) done_cnt++;
      if (drop) drop_cnt++;
      if (!csn && wrn) read_cnt++;
   endtask

   // Inputs change at negedge; model and DUT both sample at posedge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic idle_in();
      strobe = 0; valid = 0; data = 16'h0;
   endtask

   initial begin
      int acc;
      int d0;
      rst = 1; flag = 0; idle_in();
      repeat (3) tick();
      chk("rst_csn", int'(csn), 1);
      chk("rst_addr", int'(addr), 0);
      chk("rst_busy", int'(busy), 0);
      rst = 0;
      tick();

      // periodic read bursts
      read_cnt = 0; drop_cnt = 0;
      for (int s = 0; s < 4; s++) begin
         strobe = 1; tick(); strobe = 0;
         if (s == 0) begin
            chk("rd_first_csn", int'(csn), 0);
            chk("rd_first_addr", int'(addr), 0);
            repeat (9) tick();
            chk("rd_last_addr", int'(addr), 9);
            tick();
            chk("rd_end_csn", int'(csn), 1);
            repeat (9) tick();
         end else repeat (19) tick();
      end
      chk("rd_count", read_cnt, 40);
      chk("rd_no_drop", drop_cnt, 0);

      // full back-to-back load
      done_cnt = 0;
      flag = 1; tick();
      for (int i = 0; i < 40; i++) begin
         valid = 1; data = 16'h1000 + 16'(i); tick();
         if (i == 0) chk("ld_first_addr", int'(addr), 0);
      end
      chk("ld_done", int'(done), 1);
      chk("ld_last_addr", int'(addr), 'h39);
      chk("ld_last_data", int'(wdata), 'h1027);
      valid = 0; repeat (3) tick();
      chk("full_ready", int'(ready), 0);
      chk("full_busy", int'(busy), 1);
      flag = 0; repeat (2) tick();
      chk("ld_done_cnt", done_cnt, 1);

      // load with gaps in valid
      flag = 1; tick();
      acc = 0;
      for (int c = 0; c < 300 && acc < 40; c++) begin
         valid = 1'($urandom_range(0, 1));
         data = 16'($urandom);
         if (valid && ready) acc++;
         tick();
      end
      chk("gap_accepted", acc, 40);
      valid = 0; flag = 0; repeat (2) tick();

      // abort after 15 words, then restart
      done_cnt = 0;
      flag = 1; tick();
      for (int i = 0; i < 15; i++) begin
         valid = 1; data = 16'h2000 + 16'(i); tick();
      end
      valid = 0; flag = 0; repeat (3) tick();
      chk("abort_busy", int'(busy), 0);
      flag = 1; tick();
      valid = 1; data = 16'hABCD; tick();
      chk("restart_addr", int'(addr), 0);
      chk("restart_wrn", int'(wrn), 0);
      chk("abort_no_done", done_cnt, 0);
      valid = 0; flag = 0; repeat (2) tick();

      // strobe and flag together, strobe inside a burst
      drop_cnt = 0;
      flag = 1; strobe = 1; tick();
      chk("both_drop", int'(drop), 1);
      chk("both_busy", int'(busy), 1);
      strobe = 0; flag = 0; repeat (2) tick();
      strobe = 1; tick(); strobe = 0;
      repeat (4) tick();
      strobe = 1; tick(); strobe = 0;
      chk("burst_drop", int'(drop), 1);
      repeat (4) tick();
      chk("burst_tail_addr", int'(addr), 9);
      repeat (3) tick();
      chk("drop_cnt", drop_cnt, 2);

      // reset in the middle of a burst
      strobe = 1; tick(); strobe = 0;
      repeat (4) tick();
      chk("pre_rst_addr", int'(addr), 4);
      rst = 1; tick();
      chk("mid_rst_csn", int'(csn), 1);
      chk("mid_rst_addr", int'(addr), 0);
      rst = 0; tick();
      strobe = 1; tick(); strobe = 0;
      chk("post_rst_addr", int'(addr), 0);
      chk("post_rst_csn", int'(csn), 0);
      repeat (12) tick();

      // random traffic
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 39) == 0) flag = ~flag;
         strobe = ($urandom_range(0, 14) == 0);
         valid = 1'($urandom_range(0, 1));
         data = 16'($urandom);
         rst = ($urandom_range(0, 399) == 0);
         tick();
      end
      rst = 0; idle_in(); flag = 0;
      repeat (15) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
